// File: rtl/ws2812_rx_decoder_pkg.sv
// WS2812 receive decoder: state encoding and default pulse timings.
// Timings are clock-cycle counts at 100 MHz.
package timing_constants;

    typedef enum logic [1:0] {
        WAIT_RESET,
        READY,
        HIGH,
        LOW
    } state_t;

    localparam int DEF_W_COUNT = 16;
    localparam int DEF_T0H_MIN = 25;
    localparam int DEF_T0H_MAX = 55;
    localparam int DEF_T1H_MIN = 65;
    localparam int DEF_T1H_MAX = 95;
    localparam int DEF_TL_MIN  = 30;
    localparam int DEF_TL_MAX  = 90;
    localparam int DEF_TRESET  = 5000;

endpackage

// File: rtl/ws2812_rx_decoder_din_sync_2ff.sv
// Two-flop synchroniser for the asynchronous WS2812 data line.
// Adds two cycles of latency.
module din_sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic i_din,
    output logic o_din_s
);

    logic r_s1;
    logic r_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_din;
            r_s2 <= r_s1;
        end
    end

    assign o_din_s = r_s2;

endmodule

// File: rtl/ws2812_rx_decoder.sv
// WS2812 serial receiver: measures pulse widths, decodes 24-bit
// pixels and hands them out through a valid/ready output register.
module ws2812_rx_decoder
    import timing_constants::*;
#(
    parameter int W_COUNT = DEF_W_COUNT,
    parameter int T0H_MIN = DEF_T0H_MIN,
    parameter int T0H_MAX = DEF_T0H_MAX,
    parameter int T1H_MIN = DEF_T1H_MIN,
    parameter int T1H_MAX = DEF_T1H_MAX,
    parameter int TL_MIN  = DEF_TL_MIN,
    parameter int TL_MAX  = DEF_TL_MAX,
    parameter int TRESET  = DEF_TRESET
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_din,
    output logic [23:0] o_pixel,
    output logic        o_valid,
    input  logic        i_ready,
    output logic        o_frame_end,
    output logic        o_error,
    output logic        o_overflow
);

    state_t               r_state;
    logic [W_COUNT-1:0]   r_cnt;
    logic [22:0]          r_shift;
    logic [4:0]           r_bits;
    logic [23:0]          r_pixel;
    logic                 r_valid;
    logic                 r_frame_end;
    logic                 r_error;
    logic                 r_overflow;

    logic                 w_din;
    logic [W_COUNT-1:0]   w_cnt_inc;
    logic                 w_is0;
    logic                 w_is1;
    logic                 w_tl_ok;
    logic                 w_fall_ok;
    logic                 w_done;
    logic [23:0]          w_px;

    din_sync_2ff u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_din   (i_din),
        .o_din_s (w_din)
    );

    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
    assign w_is0 = (r_cnt >= W_COUNT'(T0H_MIN))
                && (r_cnt <= W_COUNT'(T0H_MAX));
    assign w_is1 = (r_cnt >= W_COUNT'(T1H_MIN))
                && (r_cnt <= W_COUNT'(T1H_MAX));
    assign w_tl_ok = (r_cnt >= W_COUNT'(TL_MIN))
                  && (r_cnt <= W_COUNT'(TL_MAX));
    assign w_fall_ok = (r_state == HIGH) && !w_din
                    && (w_is0 || w_is1);
    assign w_done = w_fall_ok && (r_bits == 5'd23);
    assign w_px = {r_shift, w_is1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= WAIT_RESET;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_bits      <= '0;
            r_pixel     <= '0;
            r_valid     <= 1'b0;
            r_frame_end <= 1'b0;
            r_error     <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_frame_end <= 1'b0;
            r_error     <= 1'b0;
            r_overflow  <= 1'b0;

            // Held pixel wins over a new one when downstream stalls.
            if (w_done) begin
                if (!r_valid || i_ready) begin
                    r_pixel <= w_px;
                    r_valid <= 1'b1;
                end else begin
                    r_overflow <= 1'b1;
                end
            end else if (r_valid && i_ready) begin
                r_valid <= 1'b0;
            end

            unique case (r_state)
                WAIT_RESET: begin
                    if (w_din) begin
                        r_cnt <= '0;
                    end else if (w_cnt_inc == W_COUNT'(TRESET)) begin
                        r_cnt   <= '0;
                        r_state <= READY;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                READY: begin
                    if (w_din) begin
                        r_cnt   <= W_COUNT'(1);
                        r_state <= HIGH;
                    end
                end
                HIGH: begin
                    if (w_din) begin
                        r_cnt <= w_cnt_inc;
                    end else if (w_fall_ok) begin
                        r_shift <= w_px[22:0];
                        r_bits  <= w_done ? 5'd0 : r_bits + 5'd1;
                        r_cnt   <= W_COUNT'(1);
                        r_state <= LOW;
                    end else begin
                        r_error <= 1'b1;
                        r_bits  <= '0;
                        r_shift <= '0;
                        r_cnt   <= '0;
                        r_state <= WAIT_RESET;
                    end
                end
                LOW: begin
                    if (w_din) begin
                        if (w_tl_ok) begin
                            r_cnt   <= W_COUNT'(1);
                            r_state <= HIGH;
                        end else begin
                            r_error <= 1'b1;
                            r_bits  <= '0;
                            r_shift <= '0;
                            r_cnt   <= '0;
                            r_state <= WAIT_RESET;
                        end
                    end else if (w_cnt_inc >= W_COUNT'(TRESET)) begin
                        r_frame_end <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= READY;
                        if (r_bits != 5'd0) begin
                            r_error <= 1'b1;
                            r_bits  <= '0;
                            r_shift <= '0;
                        end
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: r_state <= WAIT_RESET;
            endcase
        end
    end

    assign o_pixel     = r_pixel;
    assign o_valid     = r_valid;
    assign o_frame_end = r_frame_end;
    assign o_error     = r_error;
    assign o_overflow  = r_overflow;

endmodule

// File: tb/tb_ws2812_rx_decoder.sv
// Self-checking bench for ws2812_rx_decoder: drives timed WS2812
// waveforms and compares against a pulse-width reference model.
module tb_ws2812_rx_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_din = 1'b0;
    logic        i_ready = 1'b1;
    logic [23:0] o_pixel;
    logic        o_valid;
    logic        o_frame_end;
    logic        o_error;
    logic        o_overflow;

    int n_checks = 0;
    int n_fail = 0;

    int n_err = 0;
    int n_fe = 0;
    int n_ovf = 0;
    int n_both = 0;
    int n_vcyc = 0;
    logic [23:0] mon_q[$];

    ws2812_rx_decoder dut (
        .clk         (clk),
        .rst         (rst),
        .i_din       (i_din),
        .o_pixel     (o_pixel),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_frame_end (o_frame_end),
        .o_error     (o_error),
        .o_overflow  (o_overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (o_valid) n_vcyc++;
            if (o_valid && i_ready) mon_q.push_back(o_pixel);
            if (o_error) n_err++;
            if (o_frame_end) n_fe++;
            if (o_overflow) n_ovf++;
            if (o_error && o_frame_end) n_both++;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference decode of a high-pulse width: 0, 1 or -1 (error).
    function automatic int ref_bit(int th);
        if (th >= 25 && th <= 55) return 0;
        if (th >= 65 && th <= 95) return 1;
        return -1;
    endfunction

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_pulse(int th, int tl);
        i_din = 1'b1;
        cyc(th);
        i_din = 1'b0;
        cyc(tl);
    endtask

    task automatic send_pixel(logic [23:0] px, int t0, int t1, int tl);
        for (int i = 23; i >= 0; i--)
            send_pulse(px[i] ? t1 : t0, tl);
    endtask

    task automatic hold_low();
        i_din = 1'b0;
        cyc(5100);
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(3);
        n_checks++;
        if ({o_pixel, o_valid, o_frame_end, o_error, o_overflow} !== 28'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %0h expected 0",
                     {o_pixel, o_valid, o_frame_end, o_error, o_overflow});
        end
        rst = 1'b0;
        cyc(2);
        n_checks++;
        if (o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid_after_release: got %0b expected 0", o_valid);
        end
    endtask

    task automatic test_pixel();
        int e0;
        mon_q.delete();
        e0 = n_err;
        n_vcyc = 0;
        i_ready = 1'b1;
        hold_low();
        send_pixel(24'hA5C3F0, 40, 80, 60);
        cyc(20);
        n_checks++;
        if (mon_q.size() != 1) begin
            n_fail++;
            $display("FAIL pixel_count: got %0d expected 1", mon_q.size());
        end else begin
            n_checks++;
            if (mon_q[0] !== 24'hA5C3F0) begin
                n_fail++;
                $display("FAIL pixel_value: got %0h expected a5c3f0", mon_q[0]);
            end
        end
        n_checks++;
        if (n_vcyc != 1) begin
            n_fail++;
            $display("FAIL pixel_valid_cycles: got %0d expected 1", n_vcyc);
        end
        n_checks++;
        if (n_err != e0) begin
            n_fail++;
            $display("FAIL pixel_no_error: got %0d expected %0d", n_err, e0);
        end
        hold_low();
    endtask

    task automatic test_random();
        logic [23:0] exp_q[$];
        int fe0;
        int e0;
        mon_q.delete();
        fe0 = n_fe;
        e0 = n_err;
        for (int p = 0; p < 4; p++) begin
            logic [23:0] acc;
            acc = '0;
            for (int i = 0; i < 24; i++) begin
                int b;
                int th;
                int tl;
                b = $urandom_range(1, 0);
                th = b ? $urandom_range(95, 65) : $urandom_range(55, 25);
                tl = $urandom_range(90, 30);
                acc = {acc[22:0], ref_bit(th) == 1};
                send_pulse(th, tl);
            end
            exp_q.push_back(acc);
        end
        hold_low();
        n_checks++;
        if (mon_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL rand_count: got %0d expected %0d",
                     mon_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[k]) begin
                n_checks++;
                if (mon_q[k] !== exp_q[k]) begin
                    n_fail++;
                    $display("FAIL rand_pixel%0d: got %0h expected %0h",
                             k, mon_q[k], exp_q[k]);
                end
            end
        end
        chk("rand_frame_end", n_fe - fe0, 1);
        chk("rand_no_error", n_err - e0, 0);
    endtask

    task automatic test_bad_pulse();
        int e0;
        mon_q.delete();
        e0 = n_err;
        send_pulse(60, 40);
        chk("bad_pulse_error", n_err - e0, 1);
        send_pixel(24'h5A5A5A, 30, 70, 35);
        hold_low();
        chk("bad_pulse_ignored", mon_q.size(), 0);
        send_pixel(24'h0F0F0F, 30, 70, 35);
        cyc(10);
        n_checks++;
        if (mon_q.size() != 1 || mon_q[0] !== 24'h0F0F0F) begin
            n_fail++;
            $display("FAIL bad_pulse_recover: got %0d pixels expected 1 of 0f0f0f",
                     mon_q.size());
        end
        hold_low();
    endtask

    task automatic test_partial();
        int e0;
        int fe0;
        int b0;
        mon_q.delete();
        e0 = n_err;
        fe0 = n_fe;
        b0 = n_both;
        for (int i = 0; i < 12; i++)
            send_pulse((i % 3 == 0) ? 70 : 30, 35);
        hold_low();
        chk("partial_frame_end", n_fe - fe0, 1);
        chk("partial_error", n_err - e0, 1);
        chk("partial_same_cycle", n_both - b0, 1);
        chk("partial_no_pixel", mon_q.size(), 0);
        chk("partial_valid", o_valid, 0);
    endtask

    task automatic test_overflow();
        int o0;
        mon_q.delete();
        o0 = n_ovf;
        i_ready = 1'b0;
        send_pixel(24'h111111, 30, 70, 35);
        send_pixel(24'h222222, 30, 70, 35);
        cyc(20);
        chk("ovf_pulse", n_ovf - o0, 1);
        chk("ovf_valid_held", o_valid, 1);
        chk("ovf_pixel_held", o_pixel, 24'h111111);
        hold_low();
        chk("ovf_pixel_after_frame", o_pixel, 24'h111111);
        chk("ovf_valid_after_frame", o_valid, 1);
        i_ready = 1'b1;
        cyc(3);
        n_checks++;
        if (mon_q.size() != 1 || mon_q[0] !== 24'h111111) begin
            n_fail++;
            $display("FAIL ovf_drain: got %0d pixels expected 1 of 111111",
                     mon_q.size());
        end
        chk("ovf_valid_cleared", o_valid, 0);
    endtask

    task automatic test_rst_midframe();
        logic [23:0] px;
        mon_q.delete();
        i_ready = 1'b0;
        send_pixel(24'h00FF00, 30, 70, 35);
        chk("rst_pre_valid", o_valid, 1);
        px = 24'h3C3C3C;
        for (int i = 23; i > 14; i--)
            send_pulse(px[i] ? 70 : 30, 35);
        i_din = 1'b1;
        cyc(20);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({o_pixel, o_valid, o_frame_end, o_error, o_overflow} !== 28'd0) begin
            n_fail++;
            $display("FAIL rst_async_outputs: got %0h expected 0",
                     {o_pixel, o_valid, o_frame_end, o_error, o_overflow});
        end
        i_din = 1'b0;
        cyc(3);
        rst = 1'b0;
        i_ready = 1'b1;
        cyc(5);
        send_pixel(24'hC0FFEE, 30, 70, 35);
        cyc(10);
        chk("rst_no_decode", mon_q.size(), 0);
        chk("rst_no_valid", o_valid, 0);
        hold_low();
    endtask

    task automatic test_boundaries();
        logic [23:0] acc;
        int e0;
        mon_q.delete();
        e0 = n_err;
        acc = '0;
        for (int i = 0; i < 24; i++) begin
            int th;
            if (i % 2 == 0) th = (i % 4 == 0) ? 65 : 95;
            else th = (i % 4 == 1) ? 25 : 55;
            acc = {acc[22:0], ref_bit(th) == 1};
            send_pulse(th, (i % 3 == 0) ? 30 : 90);
        end
        cyc(5);
        n_checks++;
        if (mon_q.size() != 1 || mon_q[0] !== acc) begin
            n_fail++;
            $display("FAIL bound_pixel: got %0d pixels (%0h) expected 1 of %0h",
                     mon_q.size(), mon_q.size() ? mon_q[0] : 24'h0, acc);
        end
        chk("bound_no_error", n_err - e0, 0);
        hold_low();
        e0 = n_err;
        send_pulse(96, 40);
        chk("bound_t1h_96", n_err - e0, 1);
        hold_low();
        e0 = n_err;
        send_pulse(24, 40);
        chk("bound_t0h_24", n_err - e0, 1);
    endtask

    initial begin
        test_reset();
        test_pixel();
        test_random();
        test_bad_pulse();
        test_partial();
        test_overflow();
        test_rst_midframe();
        test_boundaries();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ws2812_rx_decoder.md
WS2812_RX_DECODER -- requirements
Module: ws2812_rx_decoder

Interface
REQ-001 SHALL have parameter W_COUNT, default 16, pulse-width counter width.
REQ-002 SHALL have parameters T0H_MIN 25, T0H_MAX 55, T1H_MIN 65, T1H_MAX 95, TL_MIN 30, TL_MAX 90, TRESET 5000; these are clock-cycle counts at 100 MHz.
REQ-003 SHALL have port clk, input, 1, sole clock.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port i_din, input, 1, asynchronous WS2812 serial line.
REQ-006 SHALL have port o_pixel, output, 24, received pixel, first-received bit at [23] (G[7]).
REQ-007 SHALL have port o_valid, output, 1, o_pixel holds an unconsumed pixel.
REQ-008 SHALL have port i_ready, input, 1, downstream accepts o_pixel.
REQ-009 SHALL have port o_frame_end, output, 1, one-cycle pulse when a reset-low is detected.
REQ-010 SHALL have port o_error, output, 1, one-cycle pulse on a timing violation or a partial pixel.
REQ-011 SHALL have port o_overflow, output, 1, one-cycle pulse when a completed pixel is dropped.

Function
REQ-012 SHALL synchronise i_din through two flops; all timing SHALL use the synchronised signal (din_s), giving 2-cycle input latency.
REQ-013 SHALL implement states WAIT_RESET, READY, HIGH and LOW.
REQ-014 WAIT_RESET: SHALL count consecutive din_s=0 cycles, clear the count on din_s=1, and go to READY when the count reaches TRESET.
REQ-015 READY: on a din_s rising edge SHALL go to HIGH with the counter set to 1.
REQ-016 HIGH: SHALL increment the counter each cycle din_s=1, saturating at all-ones, with no wrap.
REQ-017 On a falling edge in HIGH, a count in [T0H_MIN,T0H_MAX] SHALL shift in 0, a count in [T1H_MIN,T1H_MAX] SHALL shift in 1, and the state SHALL go to LOW with the counter set to 1.
REQ-018 On a falling edge in HIGH with the count outside both windows, the block SHALL pulse o_error, clear the bit count and shift register, and go to WAIT_RESET.
REQ-019 LOW: SHALL increment the counter while din_s=0. On a rising edge with the count in [TL_MIN,TL_MAX] it SHALL go to HIGH; any other count SHALL act as REQ-018.
REQ-020 LOW: when the count reaches TRESET, the block SHALL pulse o_frame_end and go to READY. If bit count ≠0 it SHALL also pulse o_error and discard the partial bits.
REQ-021 Bits SHALL shift MSB-first into a 24-bit register. A 5-bit bit count SHALL wrap 23→0 when the 24th bit completes a pixel.
REQ-022 A completed pixel SHALL load o_pixel and set o_valid in the cycle after the falling edge that completes it.
REQ-023 o_valid SHALL clear on o_valid&&i_ready unless a new pixel completes in the same cycle; in that case the new pixel SHALL load and o_valid SHALL stay 1.
REQ-024 If a pixel completes while o_valid=1 and i_ready=0, the block SHALL pulse o_overflow, keep the held pixel, and drop the new pixel.
REQ-025 o_pixel SHALL be stable while o_valid=1 and i_ready=0.
REQ-026 o_frame_end and o_error in the same cycle SHALL both assert; a frame_end pulse SHALL NOT clear o_valid.

Reset
REQ-027 rst=1 SHALL asynchronously set: state WAIT_RESET; counter, shift register, bit count and sync flops 0; o_pixel 0; o_valid, o_frame_end, o_error, o_overflow 0.
REQ-028 After rst deasserts mid-frame, the block SHALL decode no bits until a full TRESET low is seen.

Structure
REQ-029 Package timing_constants SHALL hold the state enum typedef and the default cycle constants; module parameters SHALL default from them.
REQ-030 The two-flop synchroniser SHALL be a sub-module named din_sync_2ff.

Verification
REQ-031 Hold low 5000 cycles, then send 24 bits of 0xA5C3F0 (T0H=40, T1H=80, TL=60) with i_ready=1 -> o_valid one cycle with o_pixel=0x A5C3F0, no o_error.
REQ-032 Drive one high pulse of 60 cycles after WAIT_RESET has cleared -> o_error pulse, then ignore all bits until 5000 low cycles pass.
REQ-033 Send 12 valid bits then hold low 5000 cycles -> o_frame_end and o_error in the same cycle, o_valid stays 0.
REQ-034 Send two pixels 0x111111 then 0x222222 with i_ready=0 -> o_overflow at the second pixel; o_pixel stays 0x111111 until i_ready=1.
REQ-035 Assert rst during bit 10 -> all outputs 0 immediately; a following 24-bit pixel with no preceding 5000-cycle low produces no o_valid.
REQ-036 Pulse-width boundaries: T1H=65 and 95 -> decoded as 1; T1H=96 and T0H=24 -> o_error.
